sync_fifo_stat: RTL
===================

Name: sync_fifo_stat

Overview:
Single-clock, parametrised FIFO for pixel/data buffering inside one clock domain of the data producer/processor path. It is the same-domain successor to the team's dual-clock pixel FIFO, generalised in width and depth. It adds occupancy reporting, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. An optional registered-output read mode is available.

Parameters:
DATA_WIDTH, 8, bits per entry
DEPTH, 32, number of entries; power of two, >= 4
ADDR_WIDTH, 5, log2(DEPTH); must match DEPTH
AF_LEVEL, 28, almost_full asserts when level >= AF_LEVEL; 1 <= AF_LEVEL <= DEPTH
AE_LEVEL, 4, almost_empty asserts when level <= AE_LEVEL; 0 <= AE_LEVEL < DEPTH

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of contents and flags
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data
full  output  1  no free entry
almost_full  output  1  level >= AF_LEVEL
rd_en  input  1  read request (pop)
rd_data  output  DATA_WIDTH  read data
empty  output  1  no valid entry
almost_empty  output  1  level <= AE_LEVEL
rd_valid  output  1  rd_data qualifier (see Optional Feature)
level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_valid=0. Memory contents are not reset.
- Pointers: binary, ADDR_WIDTH+1 bits. The MSB is the wrap bit. Memory is addressed by the low ADDR_WIDTH bits. Increment wraps modulo 2*DEPTH.
- Write accepted = wr_en && !full. Data is stored at wr_ptr, then wr_ptr increments.
- Read accepted = rd_en && !empty. rd_ptr increments.
- level is a registered counter:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged on both or neither.
  - Must always equal wr_ptr - rd_ptr.
- full = (level == DEPTH). empty = (level == 0). Thresholds are compared against level. All status outputs are valid in the same cycle the level register updates; there is no extra latency.
- Write while full: rejected, contents unchanged, overflow set. Writing while full with a same-cycle read is also rejected (no pass-through).
- Read while empty: rejected, rd_ptr unchanged, underflow set. A simultaneous write is still accepted.
- Simultaneous accepted read and write at any 0 < level < DEPTH: level unchanged, both pointers advance.
- Write-to-read latency: data written at edge N is visible and empty=0 after edge N.
- Flush (synchronous) has priority over wr_en, rd_en and clr_err in the same cycle. It clears pointers, level, overflow and underflow, and forces the reset values of all outputs on the next edge. Inputs in that cycle are ignored.
- clr_err clears both sticky flags. If an error event and clr_err occur in the same cycle, the error wins and the flag stays set.
- Reset asserted mid-transfer: immediate return to reset state. Prior contents are considered lost.

Optional Feature:
Macro SYNC_FIFO_REG_OUT_EN.
- Defined:
  - rd_data is registered.
  - An accepted read at edge N presents the head word on rd_data with rd_valid=1 after edge N, for one cycle.
  - rd_valid=0 otherwise.
  - rd_data resets to 0 and holds its value between reads.
  - Flush clears rd_valid.
- Undefined (default):
  - Show-ahead mode: rd_data is combinational from mem[rd_ptr] and is the head word while empty=0.
  - rd_valid = !empty.
  - rd_data is don't-care while empty.

Decomposition:
- Package fifo_pkg holds:
  - a clog2 function;
  - the default DATA_WIDTH and DEPTH constants;
  - a parameter-legality check (DEPTH power of two; ADDR_WIDTH == clog2(DEPTH); AF/AE ranges), which errors at elaboration.
- Sub-module fifo_mem_dp: DATA_WIDTH x DEPTH array with one synchronous write port and one asynchronous read port. Control, counter and flags stay in sync_fifo_stat.

Test Plan:
1. Reset, then 32 writes of 0x00..0x1F with no reads -> level increments to 32. almost_full rises at level 28. full=1 after the 32nd write. A 33rd write sets overflow=1, level stays 32.
2. From full, 32 reads -> data 0x00..0x1F in order. almost_empty rises at level 4. empty=1 at level 0. A further rd_en sets underflow=1.
3. Fill to 16, then 100 cycles of simultaneous wr_en/rd_en with an incrementing pattern -> level constant at 16, output order matches input order, pointer wrap covered.
4. Fill to 20, assert flush together with wr_en and rd_en -> next cycle level=0, empty=1, almost_empty=1, flags 0, no write committed.
5. With overflow set, assert clr_err in the same cycle as a new write-while-full -> overflow remains 1. clr_err alone next cycle -> overflow=0.
6. SYNC_FIFO_REG_OUT_EN defined: write 0xA5, read at edge N -> rd_data=0xA5 and rd_valid=1 for exactly one cycle after edge N. Assert rst_n low mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration-time helpers for the single-clock status FIFO.
// Used by sync_fifo_stat (built with or without SYNC_FIFO_REG_OUT_EN),
// sync_fifo_stat_if and fifo_mem_dp.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 32;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Returns 1 when the FIFO parameter set is self-consistent.
  function automatic bit params_legal(input int depth, input int addr_width,
                                      input int af_level, input int ae_level);
    bit ok;
    ok = 1'b1;
    if (depth < 4) ok = 1'b0;
    if ((depth & (depth - 1)) != 0) ok = 1'b0;
    if (addr_width != clog2(depth)) ok = 1'b0;
    if ((af_level < 1) || (af_level > depth)) ok = 1'b0;
    if ((ae_level < 0) || (ae_level >= depth)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo_stat_if.sv
// Producer/consumer bundle of the status FIFO. The master modport is the
// user side (drives requests, observes status); the slave modport is the FIFO.
interface sync_fifo_stat_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 5
);

  logic                  flush;
  logic                  clr_err;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  almost_empty;
  logic                  rd_valid;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, empty, almost_empty, rd_valid,
           level, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, empty, almost_empty, rd_valid,
           level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// Storage array for the status FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: store one word on each enabled clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_stat.sv
// Single-clock FIFO with occupancy, almost-full/empty thresholds, flush and
// sticky overflow/underflow flags. Define SYNC_FIFO_REG_OUT_EN for a
// registered read port (rd_valid pulses one cycle per pop); otherwise the
// head word is shown ahead combinationally and rd_valid = !empty.
module sync_fifo_stat
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_stat_if.slave bus
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

  if (!params_legal(DEPTH, ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_stat: illegal DEPTH/ADDR_WIDTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  mem_we_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;

  // Next-state for pointers, occupancy, flags; flush overrides everything.
  always_comb begin
    wr_acc_s = bus.wr_en && !full_q;
    rd_acc_s = bus.rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    mem_we_s = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = {LW{1'b0}};
      rd_ptr_d = {LW{1'b0}};
      level_d  = {LW{1'b0}};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      mem_we_s = wr_acc_s;
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + LW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + LW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      // An error event in the same cycle as clr_err keeps the flag set.
      if (bus.wr_en && full_q) begin
        ovf_d = 1'b1;
      end else if (bus.clr_err) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
      if (bus.rd_en && empty_q) begin
        unf_d = 1'b1;
      end else if (bus.clr_err) begin
        unf_d = 1'b0;
      end else begin
        unf_d = unf_q;
      end
    end
    // Status flags are derived from the next level so they register together.
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == {LW{1'b0}});
    af_d    = (level_d >= AF_L);
    ae_d    = (level_d <= AE_L);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {LW{1'b0}};
      rd_ptr_q <= {LW{1'b0}};
      level_q  <= {LW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata_s)
  );

  assign bus.level        = level_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

`ifdef SYNC_FIFO_REG_OUT_EN
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  // Capture the head word on an accepted pop; hold otherwise, clear on flush.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (bus.flush) begin
      rd_valid_d = 1'b0;
      rd_data_d  = {DATA_WIDTH{1'b0}};
    end else if (rd_acc_s) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem_rdata_s;
    end else begin
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`else
  assign bus.rd_data  = mem_rdata_s;
  assign bus.rd_valid = !empty_q;
`endif

endmodule
